// File: rtl/act_pkg.sv
// Shared types for the in-place activation engine.
// Optional build macro: ACT_STATS_EN (adds sat_count to act_inplace_pipe).
package act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU  = 2'd0,
        ACT_LEAKY = 2'd1,
        ACT_CLAMP = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } act_state_t;

    // Address width for n elements, never narrower than one bit.
    function automatic int act_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/act_func.sv
// Combinational activation: ReLU, leaky ReLU (arithmetic shift), clamped ReLU.
// Optional build macro: ACT_STATS_EN (consumer of the changed flag).
module act_func
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEAK_SHIFT = 3
) (
    input  act_mode_t                     mode,
    input  logic signed [DATA_WIDTH-1:0]  x,
    input  logic signed [DATA_WIDTH-1:0]  clamp_max,
    output logic signed [DATA_WIDTH-1:0]  y,
    output logic                          changed
);

    // Select the activation; a negative bound forces every clamped output to 0.
    always_comb begin
        y       = x;
        changed = 1'b0;
        unique case (mode)
            ACT_LEAKY: begin
                if (x < 0) begin
                    y       = x >>> LEAK_SHIFT;
                    changed = 1'b1;
                end
            end
            ACT_CLAMP: begin
                if (x < 0) begin
                    y       = '0;
                    changed = 1'b1;
                end else if (x > clamp_max) begin
                    y       = (clamp_max < 0) ? '0 : clamp_max;
                    changed = 1'b1;
                end
            end
            default: begin
                if (x < 0) begin
                    y       = '0;
                    changed = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/act_inplace_pipe.sv
// In-place activation pass over a CHW map: read on port A, write back on port B.
// Optional build macro: ACT_STATS_EN (adds sat_count output).
module act_inplace_pipe
    import act_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int CHANNELS   = 8,
    parameter  int IMG_SIZE   = 28,
    parameter  int RD_LATENCY = 1,
    parameter  int LEAK_SHIFT = 3,
    localparam int N          = CHANNELS * IMG_SIZE * IMG_SIZE,
    localparam int AW         = act_aw(N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic signed [DATA_WIDTH-1:0]  clamp_max,
    output logic [AW-1:0]                 conv_r_addr,
    output logic                          conv_r_en,
    input  logic signed [DATA_WIDTH-1:0]  conv_r_q,
    output logic [AW-1:0]                 conv_w_addr,
    output logic                          conv_w_en,
    output logic                          conv_w_we,
    output logic signed [DATA_WIDTH-1:0]  conv_w_d,
    output logic                          busy,
`ifdef ACT_STATS_EN
    output logic [$clog2(N+1)-1:0]        sat_count,
`endif
    output logic                          done
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    act_state_t                   state;
    act_mode_t                    mode_q;
    logic signed [DATA_WIDTH-1:0] cmax_q;
    logic [RD_LATENCY-1:0]        vld;
    logic [AW-1:0]                addr_sr [RD_LATENCY];
    logic signed [DATA_WIDTH-1:0] act_y;
    logic                         act_changed;

    act_func #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_func (
        .mode      (mode_q),
        .x         (conv_r_q),
        .clamp_max (cmax_q),
        .y         (act_y),
        .changed   (act_changed)
    );

    // Pass sequencer: issues one read per cycle, then waits for the last write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= ACT_RELU;
            cmax_q      <= '0;
            conv_r_addr <= '0;
            conv_r_en   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q      <= act_mode_t'(mode);
                        cmax_q      <= clamp_max;
                        conv_r_addr <= '0;
                        conv_r_en   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (conv_r_addr == LAST) begin
                        conv_r_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        conv_r_addr <= conv_r_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (vld == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
            endcase
        end
    end

    // Track each issued read until its data emerges from the BRAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) addr_sr[i] <= '0;
        end else begin
            vld[0]     <= conv_r_en;
            addr_sr[0] <= conv_r_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i]     <= vld[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    // Register the activated value and write it back to its source address.
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_w_en   <= 1'b0;
            conv_w_addr <= '0;
            conv_w_d    <= '0;
        end else begin
            conv_w_en <= vld[RD_LATENCY-1];
            if (vld[RD_LATENCY-1]) begin
                conv_w_addr <= addr_sr[RD_LATENCY-1];
                conv_w_d    <= act_y;
            end
        end
    end

    assign conv_w_we = conv_w_en;

`ifdef ACT_STATS_EN
    // Count elements altered by the activation during the current pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (state == IDLE && start) begin
            sat_count <= '0;
        end else if (vld[RD_LATENCY-1] && act_changed) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`else
    logic unused_changed;
    assign unused_changed = act_changed;
`endif

endmodule
